// File: rtl/demux_1_n_stream.sv
// demux_1_n_stream: 1:N valid/ready stream demux, addressed or round-robin, one holding register per channel
module demux_1_n_stream #(
  parameter int WIDTH = 16,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic [CNT_W-1:0]       drop_cnt
);
  localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_OUT - 1);
  logic [SEL_W-1:0]     tgt;
  logic [2**SEL_W-1:0]  free;
  logic                 hit, accept, drop;
  // free is padded to the full select range so any tgt indexes it safely
  always_comb begin
    free = '0;
    for (int i = 0; i < N_OUT; i++) free[i] = ~out_valid[i] | out_ready[i];
  end
  assign tgt      = mode ? rr_ptr : in_sel;
  assign hit      = {1'b0, tgt} < N_LIM;
  assign in_ready = hit ? free[tgt] : 1'b1;
  assign accept   = in_valid & in_ready & hit;
  assign drop     = in_valid & ~hit;
  // a refill takes priority over a drain, so a same-cycle drain+accept keeps valid high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (accept && tgt == SEL_W'(i)) begin
          out_valid[i]                <= 1'b1;
          out_data[i*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]                <= 1'b0;
          out_data[i*WIDTH +: WIDTH]  <= '0;
        end
      if (accept && mode) rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + SEL_W'(1);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
endmodule

// File: doc/demux_1_n_stream.md
Name: demux_1_n_stream

Overview:
- Parametrised, registered successor of the 16-bit 1:4 demultiplexer.
- Routes one WIDTH-bit input stream to one of N_OUT output channels.
- Uses valid/ready handshakes and one holding register per output channel.
- Supports two routing modes: addressed (select input) and round-robin (internal pointer). Out-of-range selects are dropped and counted.
- Sits between a producer and N_OUT independent consumers in the datapath.

Parameters:
- WIDTH, 16, data width of the input and of each output channel.
- N_OUT, 4, number of output channels; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_OUT.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_data  input  WIDTH  input payload.
- in_sel  input  SEL_W  target channel, used in addressed mode only.
- in_valid  input  1  input payload valid.
- in_ready  output  1  block can accept the input this cycle.
- mode  input  1  0 = addressed by in_sel; 1 = round-robin.
- out_data  output  N_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  N_OUT  per-channel valid.
- out_ready  input  N_OUT  per-channel consumer ready.
- rr_ptr  output  SEL_W  current round-robin target, for observability.
- drop_cnt  output  CNT_W  number of dropped transfers, saturating.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert by the surrounding design):
  - out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0.
  - Any held data is discarded; no partial transfer survives reset.
- Target channel:
  - mode=0: tgt = in_sel.
  - mode=1: tgt = rr_ptr.
  - mode is sampled every cycle and is not latched. A mode change does not alter rr_ptr.
- Holding register of channel i:
  - It is free when out_valid[i]=0, or when out_valid[i]=1 and out_ready[i]=1 in the same cycle (drain and refill in one cycle).
- in_ready:
  - 1 if tgt >= N_OUT (mode 0 only; such transfers are dropped).
  - Otherwise equals the free condition of channel tgt.
  - in_ready depends combinationally on in_sel, mode, out_valid and out_ready. It must not depend on in_valid.
- Accept (in_valid & in_ready, valid tgt):
  - Next cycle: out_valid[tgt]=1 and out_data slice tgt = in_data.
  - Latency is exactly 1 clock from accept to out_valid.
- Drop (in_valid & in_ready, tgt >= N_OUT):
  - No output changes; drop_cnt increments by 1 and saturates at 2**CNT_W-1.
- Drain (out_valid[i] & out_ready[i], no refill of i this cycle):
  - Next cycle out_valid[i]=0 and slice i = 0.
  - Unselected or idle channels always present zero data, matching the zero-fill of the existing demux.
- Stability: while out_valid[i]=1 and out_ready[i]=0, slice i and out_valid[i] hold constant.
- Round-robin:
  - rr_ptr advances only on an accepted transfer in mode=1.
  - Sequence is 0,1,…,N_OUT-1,0 (wraps at N_OUT-1, not at 2**SEL_W-1).
  - If channel rr_ptr is busy, in_ready=0 and rr_ptr does not skip to another channel; strict order is preserved.
- Channels are independent: a stalled channel never blocks accepts to a different free channel in mode 0.
- Simultaneous events:
  - Drain of channel j and accept into channel k (j≠k) in the same cycle: both take effect.
  - Drain and accept on the same channel: the new data replaces the old with out_valid held at 1, so there is no bubble.
- out_ready of a channel with out_valid=0 is ignored.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously). The first accept after reset targets channel 0 in mode 1.

Test Plan:
- Reset, then mode=0, N_OUT=4, send 0xAAAA sel=2 with all out_ready=1 → cycle+1: out_valid=0100 and slice2=0xAAAA, other slices 0; cycle+2 (no new input): out_valid=0000 and all slices 0.
- mode=0, out_ready[1]=0, send 0x1111 sel=1, then 0x2222 sel=1 → second beat sees in_ready=0 and slice1 holds 0x1111; raise out_ready[1] → 0x2222 is accepted that same cycle and appears at cycle+1 with no bubble.
- mode=1, all out_ready=1, send 6 back-to-back beats 0x0001..0x0006 → channels 0,1,2,3,0,1 each receive them in order; rr_ptr ends at 2.
- mode=1, out_ready[2]=0 while channel 2 holds data, rr_ptr=2 → in_ready=0, rr_ptr stays 2 and no other channel is written.
- Build N_OUT=3, SEL_W=2, mode=0, send sel=3 for 300 beats → in_ready=1 each cycle, no out_valid asserts, drop_cnt saturates at 255.
- Assert rst_n=0 asynchronously while out_valid=1111 → out_valid and out_data go to 0 before the next clk edge; after release, a mode=1 accept lands in channel 0.
